dag1_share_ctrl: RTL and testbench

//  Round-robin scheduler sharing one dag1-style datapath (2-bit a/b path -> out0, 1-bit c/d path -> out1) among NREQ requesters.

---
 rtl/dag1_share_ctrl.sv | 161 ++++++++++++++++
 tb/tb_dag1_share_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/dag1_share_ctrl.sv
// Round-robin scheduler that shares one dag1-style datapath among NREQ requesters.
// One transaction is in flight at a time. The granted operands are held on dp_* for the
// datapath latency. The datapath result is then captured and returned on a valid/ready port.
// Ports:
//   clock, reset                     rising-edge clock, async active-high reset
//   req, req_a, req_b, req_c, req_d  per-requester request and packed operands
//   gnt                              one-hot single-cycle pulse when operands are taken
//   dp_a_in..dp_d_in                 registered operands driven to the datapath
//   dp_out0, dp_out1                 datapath results
//   rsp_valid, rsp_ready, rsp_id,
//   rsp_out0, rsp_out1               response channel
//   busy                             high whenever the controller is not idle
module dag1_share_ctrl #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned DW      = 2,
   parameter int unsigned LATENCY = 3
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [NREQ-1:0]            req,
   input  logic [NREQ*DW-1:0]         req_a,
   input  logic [NREQ*DW-1:0]         req_b,
   input  logic [NREQ-1:0]            req_c,
   input  logic [NREQ-1:0]            req_d,
   output logic [NREQ-1:0]            gnt,
   output logic [DW-1:0]              dp_a_in,
   output logic [DW-1:0]              dp_b_in,
   output logic                       dp_c_in,
   output logic                       dp_d_in,
   input  logic [DW-1:0]              dp_out0,
   input  logic                       dp_out1,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [$clog2(NREQ)-1:0]    rsp_id,
   output logic [DW-1:0]              rsp_out0,
   output logic                       rsp_out1,
   output logic                       busy
);

   localparam int unsigned IDW = $clog2(NREQ);
   localparam int unsigned CW  = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

   typedef enum logic [1:0] {IDLE, HOLD, RESP} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [IDW-1:0]    rr_q, rr_d;
   logic [NREQ-1:0]   gnt_d;
   logic [DW-1:0]     dp_a_d, dp_b_d;
   logic              dp_c_d, dp_d_d;
   logic              rsp_valid_d;
   logic [IDW-1:0]    rsp_id_d;
   logic [DW-1:0]     rsp_out0_d;
   logic              rsp_out1_d;
   logic              busy_d;

   logic              found;
   logic [IDW-1:0]    sel;

   // First set request at or above the rr pointer, wrapping around.
   always_comb begin
      int unsigned idx;
      found = 1'b0;
      sel   = '0;
      idx   = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = 32'(rr_q) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && req[IDW'(idx)]) begin
            found = 1'b1;
            sel   = IDW'(idx);
         end
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rr_d        = rr_q;
      gnt_d       = '0;
      dp_a_d      = dp_a_in;
      dp_b_d      = dp_b_in;
      dp_c_d      = dp_c_in;
      dp_d_d      = dp_d_in;
      rsp_valid_d = rsp_valid;
      rsp_id_d    = rsp_id;
      rsp_out0_d  = rsp_out0;
      rsp_out1_d  = rsp_out1;

      case (state_q)
         IDLE: begin
            if (found) begin
               gnt_d[sel] = 1'b1;
               dp_a_d     = req_a[32'(sel)*DW +: DW];
               dp_b_d     = req_b[32'(sel)*DW +: DW];
               dp_c_d     = req_c[sel];
               dp_d_d     = req_d[sel];
               rsp_id_d   = sel;
               rr_d       = (32'(sel) == NREQ - 1) ? '0 : sel + IDW'(1);
               cnt_d      = '0;
               state_d    = HOLD;
            end
         end
         HOLD: begin
            // Operands have been stable for LATENCY edges once cnt reaches LATENCY.
            if (cnt_q == CW'(LATENCY)) begin
               rsp_out0_d  = dp_out0;
               rsp_out1_d  = dp_out1;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and output registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rr_q      <= '0;
         gnt       <= '0;
         dp_a_in   <= '0;
         dp_b_in   <= '0;
         dp_c_in   <= 1'b0;
         dp_d_in   <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_out0  <= '0;
         rsp_out1  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rr_q      <= rr_d;
         gnt       <= gnt_d;
         dp_a_in   <= dp_a_d;
         dp_b_in   <= dp_b_d;
         dp_c_in   <= dp_c_d;
         dp_d_in   <= dp_d_d;
         rsp_valid <= rsp_valid_d;
         rsp_id    <= rsp_id_d;
         rsp_out0  <= rsp_out0_d;
         rsp_out1  <= rsp_out1_d;
         busy      <= busy_d;
      end
   end

endmodule

// File: tb/tb_dag1_share_ctrl.sv
// Testbench for dag1_share_ctrl.
// The shared datapath is modelled as a LATENCY-deep pipeline.
// Its outputs are out0 = 0 and out1 = d & ~c.
module tb_dag1_share_ctrl;

   localparam int unsigned NREQ    = 4;
   localparam int unsigned DW      = 2;
   localparam int unsigned LATENCY = 3;

   logic                clock;
   logic                reset;
   logic [NREQ-1:0]     req;
   logic [NREQ*DW-1:0]  req_a, req_b;
   logic [NREQ-1:0]     req_c, req_d;
   logic [NREQ-1:0]     gnt;
   logic [DW-1:0]       dp_a_in, dp_b_in;
   logic                dp_c_in, dp_d_in;
   logic [DW-1:0]       dp_out0;
   logic                dp_out1;
   logic                rsp_valid, rsp_ready;
   logic [1:0]          rsp_id;
   logic [DW-1:0]       rsp_out0;
   logic                rsp_out1;
   logic                busy;

   int total = 0;
   int bad   = 0;

   dag1_share_ctrl #(.NREQ(NREQ), .DW(DW), .LATENCY(LATENCY)) dut (
      .clock(clock), .reset(reset),
      .req(req), .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
      .gnt(gnt),
      .dp_a_in(dp_a_in), .dp_b_in(dp_b_in), .dp_c_in(dp_c_in), .dp_d_in(dp_d_in),
      .dp_out0(dp_out0), .dp_out1(dp_out1),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_out0(rsp_out0), .rsp_out1(rsp_out1), .busy(busy)
   );

   // Datapath model: result appears LATENCY edges after the operands settle.
   logic [LATENCY-1:0] pipe;
   always_ff @(posedge clock or posedge reset) begin
      if (reset) pipe <= '0;
      else       pipe <= {pipe[LATENCY-2:0], dp_d_in & ~dp_c_in};
   end
   assign dp_out1 = pipe[LATENCY-1];
   assign dp_out0 = 2'b00;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic [3:0] req;
      logic [7:0] a;
      logic [7:0] b;
      logic [3:0] c;
      logic [3:0] d;
      logic [3:0] hold;   // RESP cycles with rsp_ready low
      logic [3:0] gnt;
      logic [1:0] id;
      logic       o1;
      logic [1:0] ea;
      logic [1:0] eb;
      logic       ec;
      logic       ed;
   } vec_t;

   vec_t vecs [11];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One full transaction: grant, hold, response, optional backpressure, handshake.
   task automatic run_vec(input vec_t v, input int n);
      int cyc;
      req = v.req; req_a = v.a; req_b = v.b; req_c = v.c; req_d = v.d;
      rsp_ready = 1'b0;
      tick();
      chk($sformatf("v%0d gnt", n),       32'(gnt),       32'(v.gnt));
      chk($sformatf("v%0d busy", n),      32'(busy),      32'd1);
      chk($sformatf("v%0d rsp_id", n),    32'(rsp_id),    32'(v.id));
      chk($sformatf("v%0d dp_a", n),      32'(dp_a_in),   32'(v.ea));
      chk($sformatf("v%0d dp_b", n),      32'(dp_b_in),   32'(v.eb));
      chk($sformatf("v%0d dp_c", n),      32'(dp_c_in),   32'(v.ec));
      chk($sformatf("v%0d dp_d", n),      32'(dp_d_in),   32'(v.ed));
      chk($sformatf("v%0d early_valid", n), 32'(rsp_valid), 32'd0);
      cyc = 1;
      while (rsp_valid !== 1'b1 && cyc < 20) begin
         tick();
         cyc++;
         chk($sformatf("v%0d gnt_pulse", n), 32'(gnt),     32'd0);
         chk($sformatf("v%0d hold_a", n),    32'(dp_a_in), 32'(v.ea));
         chk($sformatf("v%0d hold_c", n),    32'(dp_c_in), 32'(v.ec));
         chk($sformatf("v%0d hold_d", n),    32'(dp_d_in), 32'(v.ed));
      end
      chk($sformatf("v%0d latency", n),   32'(cyc),       32'(LATENCY + 2));
      chk($sformatf("v%0d rsp_valid", n), 32'(rsp_valid), 32'd1);
      chk($sformatf("v%0d rsp_id2", n),   32'(rsp_id),    32'(v.id));
      chk($sformatf("v%0d rsp_out0", n),  32'(rsp_out0),  32'd0);
      chk($sformatf("v%0d rsp_out1", n),  32'(rsp_out1),  32'(v.o1));
      for (int i = 0; i < int'(v.hold); i++) begin
         tick();
         chk($sformatf("v%0d bp_valid", n), 32'(rsp_valid), 32'd1);
         chk($sformatf("v%0d bp_id", n),    32'(rsp_id),    32'(v.id));
         chk($sformatf("v%0d bp_out1", n),  32'(rsp_out1),  32'(v.o1));
         chk($sformatf("v%0d bp_gnt", n),   32'(gnt),       32'd0);
         chk($sformatf("v%0d bp_busy", n),  32'(busy),      32'd1);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk($sformatf("v%0d idle_valid", n), 32'(rsp_valid), 32'd0);
      chk($sformatf("v%0d idle_busy", n),  32'(busy),      32'd0);
      chk($sformatf("v%0d idle_gnt", n),   32'(gnt),       32'd0);
      chk($sformatf("v%0d idle_dp_a", n),  32'(dp_a_in),   32'(v.ea));
      chk($sformatf("v%0d idle_dp_b", n),  32'(dp_b_in),   32'(v.eb));
   endtask

   initial begin
      //           req      a            b            c        d        hold   gnt      id     o1    ea     eb     ec    ed
      vecs[0]  = '{4'b1111, 8'b10010011, 8'b00111001, 4'b0101, 4'b0011, 4'd0,  4'b0001, 2'd0, 1'b0, 2'b11, 2'b01, 1'b1, 1'b1};
      vecs[1]  = '{4'b1111, 8'b10010011, 8'b00111001, 4'b0101, 4'b0011, 4'd0,  4'b0010, 2'd1, 1'b1, 2'b00, 2'b10, 1'b0, 1'b1};
      vecs[2]  = '{4'b1111, 8'b10010011, 8'b00111001, 4'b0101, 4'b0011, 4'd0,  4'b0100, 2'd2, 1'b0, 2'b01, 2'b11, 1'b1, 1'b0};
      vecs[3]  = '{4'b1111, 8'b10010011, 8'b00111001, 4'b0101, 4'b0011, 4'd0,  4'b1000, 2'd3, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0};
      vecs[4]  = '{4'b1111, 8'b10010011, 8'b00111001, 4'b0101, 4'b0011, 4'd2,  4'b0001, 2'd0, 1'b0, 2'b11, 2'b01, 1'b1, 1'b1};
      vecs[5]  = '{4'b0001, 8'b00000011, 8'b00000001, 4'b0000, 4'b0001, 4'd10, 4'b0001, 2'd0, 1'b1, 2'b11, 2'b01, 1'b0, 1'b1};
      vecs[6]  = '{4'b0100, 8'b00100000, 8'b00010000, 4'b0000, 4'b0100, 4'd0,  4'b0100, 2'd2, 1'b1, 2'b10, 2'b01, 1'b0, 1'b1};
      vecs[7]  = '{4'b0011, 8'b00000110, 8'b00001100, 4'b0001, 4'b0011, 4'd0,  4'b0001, 2'd0, 1'b0, 2'b10, 2'b00, 1'b1, 1'b1};
      vecs[8]  = '{4'b0011, 8'b00000110, 8'b00001100, 4'b0001, 4'b0011, 4'd0,  4'b0010, 2'd1, 1'b1, 2'b01, 2'b11, 1'b0, 1'b1};
      vecs[9]  = '{4'b0010, 8'b00001100, 8'b00001000, 4'b0010, 4'b0010, 4'd0,  4'b0010, 2'd1, 1'b0, 2'b11, 2'b10, 1'b1, 1'b1};
      vecs[10] = '{4'b1001, 8'b01000000, 8'b10000000, 4'b0000, 4'b1001, 4'd0,  4'b1000, 2'd3, 1'b1, 2'b01, 2'b10, 1'b0, 1'b1};

      reset = 1'b1; req = '0; req_a = '0; req_b = '0; req_c = '0; req_d = '0; rsp_ready = 1'b0;
      tick();
      tick();
      chk("rst busy",  32'(busy),      32'd0);
      chk("rst valid", 32'(rsp_valid), 32'd0);
      chk("rst gnt",   32'(gnt),       32'd0);
      chk("rst dp_a",  32'(dp_a_in),   32'd0);
      chk("rst id",    32'(rsp_id),    32'd0);
      reset = 1'b0;
      tick();
      chk("idle no req busy", 32'(busy), 32'd0);

      // Reset asserted during the second HOLD cycle takes effect immediately.
      req = 4'b0001; req_a = 8'h03; req_b = 8'h01; req_c = 4'b0000; req_d = 4'b0001;
      tick();
      chk("mid gnt",  32'(gnt),  32'b0001);
      chk("mid busy", 32'(busy), 32'd1);
      tick();
      #2 reset = 1'b1;
      #1;
      chk("async busy",  32'(busy),      32'd0);
      chk("async valid", 32'(rsp_valid), 32'd0);
      chk("async gnt",   32'(gnt),       32'd0);
      chk("async dp_a",  32'(dp_a_in),   32'd0);
      chk("async dp_b",  32'(dp_b_in),   32'd0);
      chk("async dp_d",  32'(dp_d_in),   32'd0);
      req = '0;
      tick();
      reset = 1'b0;
      tick();
      chk("post rst busy", 32'(busy), 32'd0);

      for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

      req = '0;
      tick();
      tick();
      chk("final gnt",  32'(gnt),  32'd0);
      chk("final busy", 32'(busy), 32'd0);
      chk("final dp_d kept", 32'(dp_d_in), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
